// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the IF-stage fetch/redirect controller:
//   - fetch_state_e : controller FSM states (BOOT, RUN)
//   - bht_ctr_e     : 2-bit saturating branch counter encodings
//   - BHT_RESET_VAL : value every BHT entry takes on reset (weakly not-taken)
//   - PC_INC        : sequential fetch increment
//   - bht_next()    : saturating counter update
// ---------------------------------------------------------------------------
package fetch_pkg;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_e;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bht_ctr_e;

    localparam bht_ctr_e    BHT_RESET_VAL = WNT;
    localparam logic [31:0] PC_INC        = 32'd4;

    // Saturating 2-bit counter step: move towards ST on taken, SNT otherwise.
    function automatic bht_ctr_e bht_next(bht_ctr_e cur, logic taken);
        bht_ctr_e nxt;
        nxt = cur;
        case (cur)
            SNT: nxt = taken ? WNT : SNT;
            WNT: nxt = taken ? WT  : SNT;
            WT:  nxt = taken ? ST  : WNT;
            ST:  nxt = taken ? ST  : WT;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/branch_history_table.sv
// ---------------------------------------------------------------------------
// branch_history_table
// Table of 2-bit saturating counters with one combinational read port and one
// synchronous update port. A read and an update to the same index in the
// same cycle return the old counter (no bypass).
// Ports:
//   clk          clock
//   reset        asynchronous active-low reset; every entry -> WNT
//   rd_idx_i     read index
//   rd_taken_o   prediction (counter MSB) at rd_idx_i
//   upd_en_i     train the entry at upd_idx_i this cycle
//   upd_idx_i    update index
//   upd_taken_i  resolved outcome used to step the counter
// ---------------------------------------------------------------------------
module branch_history_table
    import fetch_pkg::*;
#(
    parameter int ENTRIES = 64,
    localparam int IDX_W  = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic             rd_taken_o,
    input  logic             upd_en_i,
    input  logic [IDX_W-1:0] upd_idx_i,
    input  logic             upd_taken_i
);

    bht_ctr_e table_q [ENTRIES];
    bht_ctr_e rd_ctr;

    // NOTE: the whole table is reset so that training never survives a
    // reset; this rules out a RAM macro but the table is small flops anyway.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i] <= BHT_RESET_VAL;
            end
        end else if (upd_en_i) begin
            table_q[upd_idx_i] <= bht_next(table_q[upd_idx_i], upd_taken_i);
        end
    end

    assign rd_ctr     = table_q[rd_idx_i];
    assign rd_taken_o = (rd_ctr == WT) || (rd_ctr == ST);

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_redirect_ctrl
// Owns the fetch PC. Selects the next PC from EX redirect (mispredict or
// jalr), stall hold, decoder early jump, or sequential fetch, in that order.
// Supplies the BHT prediction for the current PC and trains the BHT from
// resolved EX branches.
// Ports:
//   clk, reset          clock; asynchronous active-low reset
//   stall               hazard hold, freezes pc
//   dec_jump_flag/addr  decoder early jump and its target
//   ex_valid            EX instruction is real
//   ex_is_branch/jalr   EX instruction class
//   ex_taken, ex_pred   resolved outcome and the prediction it carried
//   ex_pc, ex_target    EX instruction PC and resolved target
//   pc                  current fetch PC
//   prediction          BHT prediction for pc
//   fetch_valid         pc is a real fetch (low during BOOT)
//   flush               squash IF/ID and ID/EX (combinational)
//   br_count            resolved branches, saturating
//   mispred_count       mispredicts + jalr redirects, saturating
// ---------------------------------------------------------------------------
module fetch_redirect_ctrl
    import fetch_pkg::*;
#(
    parameter int          BHT_ENTRIES = 64,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        dec_jump_flag,
    input  logic [31:0] dec_jump_address,
    input  logic        ex_valid,
    input  logic        ex_is_branch,
    input  logic        ex_is_jalr,
    input  logic        ex_taken,
    input  logic        ex_pred,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_target,
    output logic [31:0] pc,
    output logic        prediction,
    output logic        fetch_valid,
    output logic        flush,
    output logic [15:0] br_count,
    output logic [15:0] mispred_count
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    fetch_state_e state_q;
    logic         fetch_valid_q;
    logic [31:0]  pc_q, pc_d;
    logic [15:0]  br_count_q, mispred_count_q;

    logic        run;
    logic        ex_branch_v;
    logic        ex_mispred;
    logic        ex_redirect;
    logic [31:0] redirect_pc;

    assign run = (state_q == RUN);

    // EX inputs only matter once fetching has started.
    assign ex_branch_v = run && ex_valid && ex_is_branch;
    assign ex_mispred  = ex_branch_v && (ex_taken != ex_pred);
    assign ex_redirect = ex_mispred || (run && ex_valid && ex_is_jalr);

    // A mispredicted not-taken branch resumes at the fall-through PC.
    assign redirect_pc = (ex_is_jalr || ex_taken) ? ex_target : ex_pc + PC_INC;

    // FSM with registered fetch_valid.
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= BOOT;
            fetch_valid_q <= 1'b0;
        end else begin
            case (state_q)
                BOOT: begin
                    state_q       <= RUN;
                    fetch_valid_q <= 1'b1;
                end
                RUN: begin
                    state_q       <= RUN;
                    fetch_valid_q <= 1'b1;
                end
            endcase
        end
    end

    // Next-PC select. A redirect overrides stall; stall overrides the
    // decoder jump so the decoder re-evaluates the same instruction.
    // NOTE: pc_d takes a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        pc_d = pc_q;
        if (run) begin
            if (ex_redirect) begin
                pc_d = redirect_pc;
            end else if (!stall) begin
                pc_d = dec_jump_flag ? dec_jump_address : pc_q + PC_INC;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q            <= RESET_PC;
            br_count_q      <= 16'd0;
            mispred_count_q <= 16'd0;
        end else begin
            pc_q <= pc_d;
            if (ex_branch_v && (br_count_q != 16'hFFFF)) begin
                br_count_q <= br_count_q + 16'd1;
            end
            if (ex_redirect && (mispred_count_q != 16'hFFFF)) begin
                mispred_count_q <= mispred_count_q + 16'd1;
            end
        end
    end

    branch_history_table #(
        .ENTRIES (BHT_ENTRIES)
    ) u_bht (
        .clk         (clk),
        .reset       (reset),
        .rd_idx_i    (pc_q[IDX_W+1:2]),
        .rd_taken_o  (prediction),
        .upd_en_i    (ex_branch_v),
        .upd_idx_i   (ex_pc[IDX_W+1:2]),
        .upd_taken_i (ex_taken)
    );

    assign pc            = pc_q;
    assign fetch_valid   = fetch_valid_q;
    assign flush         = ex_redirect;
    assign br_count      = br_count_q;
    assign mispred_count = mispred_count_q;

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fetch_redirect_ctrl
// Directed bench for fetch_redirect_ctrl with an abstract reference model
// (plain integers and an int array for the BHT) compared every cycle, plus
// hand-computed literal expectations at the interesting points.
// ---------------------------------------------------------------------------
module tb_fetch_redirect_ctrl;

    localparam int          ENTRIES = 64;
    localparam logic [31:0] RST_PC  = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        dec_jump_flag;
    logic [31:0] dec_jump_address;
    logic        ex_valid, ex_is_branch, ex_is_jalr, ex_taken, ex_pred;
    logic [31:0] ex_pc, ex_target;
    logic [31:0] pc;
    logic        prediction, fetch_valid, flush;
    logic [15:0] br_count, mispred_count;

    int total = 0;
    int bad   = 0;

    fetch_redirect_ctrl #(
        .BHT_ENTRIES (ENTRIES),
        .RESET_PC    (RST_PC)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .stall            (stall),
        .dec_jump_flag    (dec_jump_flag),
        .dec_jump_address (dec_jump_address),
        .ex_valid         (ex_valid),
        .ex_is_branch     (ex_is_branch),
        .ex_is_jalr       (ex_is_jalr),
        .ex_taken         (ex_taken),
        .ex_pred          (ex_pred),
        .ex_pc            (ex_pc),
        .ex_target        (ex_target),
        .pc               (pc),
        .prediction       (prediction),
        .fetch_valid      (fetch_valid),
        .flush            (flush),
        .br_count         (br_count),
        .mispred_count    (mispred_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_pc;
    bit          m_running;
    int          m_br, m_mis;
    int          m_bht [ENTRIES];

    function automatic bit m_redirect();
        bit mis;
        mis = ex_valid && ex_is_branch && (ex_taken != ex_pred);
        return mis || (ex_valid && ex_is_jalr);
    endfunction

    always @(posedge clk or negedge reset) begin
        int idx;
        if (!reset) begin
            m_pc      <= RST_PC;
            m_running <= 1'b0;
            m_br      <= 0;
            m_mis     <= 0;
            for (int i = 0; i < ENTRIES; i++) m_bht[i] <= 1;
        end else if (!m_running) begin
            m_running <= 1'b1;
        end else begin
            if (ex_valid && ex_is_branch) begin
                idx = int'(ex_pc / 4) % ENTRIES;
                if (ex_taken) m_bht[idx] <= (m_bht[idx] == 3) ? 3 : m_bht[idx] + 1;
                else          m_bht[idx] <= (m_bht[idx] == 0) ? 0 : m_bht[idx] - 1;
                m_br <= (m_br == 65535) ? 65535 : m_br + 1;
            end
            if (m_redirect()) begin
                m_mis <= (m_mis == 65535) ? 65535 : m_mis + 1;
                m_pc  <= (ex_is_jalr || ex_taken) ? ex_target : ex_pc + 32'd4;
            end else if (!stall) begin
                m_pc <= dec_jump_flag ? dec_jump_address : m_pc + 32'd4;
            end
        end
    end

    // Compare mid-cycle, after the driver has applied this cycle's inputs.
    always @(negedge clk) begin
        #3;
        if (reset) begin
            check("m_pc",     pc,            m_pc);
            check("m_fvalid", {31'd0, fetch_valid}, {31'd0, m_running});
            check("m_flush",  {31'd0, flush}, {31'd0, (m_running && m_redirect())});
            check("m_pred",   {31'd0, prediction},
                  {31'd0, (m_bht[int'(m_pc / 4) % ENTRIES] >= 2)});
            check("m_br",     {16'd0, br_count},      m_br);
            check("m_mis",    {16'd0, mispred_count}, m_mis);
        end
    end

    // ---------------- stimulus ----------------
    task automatic next_cycle();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stall            = 1'b0;
        dec_jump_flag    = 1'b0;
        dec_jump_address = 32'd0;
        ex_valid         = 1'b0;
        ex_is_branch     = 1'b0;
        ex_is_jalr       = 1'b0;
        ex_taken         = 1'b0;
        ex_pred          = 1'b0;
        ex_pc            = 32'd0;
        ex_target        = 32'd0;
    endtask

    task automatic ex_branch(input logic [31:0] bpc, input logic taken, input logic pred,
                             input logic [31:0] tgt);
        ex_valid     = 1'b1;
        ex_is_branch = 1'b1;
        ex_pc        = bpc;
        ex_taken     = taken;
        ex_pred      = pred;
        ex_target    = tgt;
    endtask

    task automatic dec_jump(input logic [31:0] addr);
        dec_jump_flag    = 1'b1;
        dec_jump_address = addr;
    endtask

    initial begin
        reset = 1'b0;
        clear_inputs();
        repeat (2) next_cycle();

        // Reset release: one BOOT cycle, then sequential fetch.
        reset = 1'b1;
        #1;
        check("boot_fvalid", {31'd0, fetch_valid}, 32'd0);
        check("boot_pc", pc, 32'h100);
        next_cycle(); #1;
        check("run_fvalid", {31'd0, fetch_valid}, 32'd1);
        check("seq_pc0", pc, 32'h100);
        next_cycle(); #1;
        check("seq_pc1", pc, 32'h104);
        next_cycle(); #1;
        check("seq_pc2", pc, 32'h108);

        // Decoder jump back to 0x104, then at 0x104 jump to 0x200.
        dec_jump(32'h104);
        next_cycle(); clear_inputs(); #1;
        check("dj_pc_104", pc, 32'h104);
        dec_jump(32'h200);
        #1;
        check("dj_flush", {31'd0, flush}, 32'd0);
        next_cycle(); clear_inputs(); #1;
        check("dj_pc_200", pc, 32'h200);

        // Branch at 0x40 taken, predicted not-taken -> redirect to 0x80.
        ex_branch(32'h40, 1'b1, 1'b0, 32'h80);
        #1;
        check("mp_flush", {31'd0, flush}, 32'd1);
        next_cycle(); clear_inputs(); #1;
        check("mp_pc", pc, 32'h80);
        check("mp_flush_gone", {31'd0, flush}, 32'd0);
        check("mp_count", {16'd0, mispred_count}, 32'd1);
        check("mp_br", {16'd0, br_count}, 32'd1);

        // Fetch 0x40: counter now 10 -> predicts taken.
        dec_jump(32'h40);
        next_cycle(); clear_inputs(); #1;
        check("bht_10_pc", pc, 32'h40);
        check("bht_10_pred", {31'd0, prediction}, 32'd1);

        // Two more correctly predicted taken resolutions (-> 11, stays 11).
        for (int k = 0; k < 2; k++) begin
            ex_branch(32'h40, 1'b1, 1'b1, 32'h80);
            #1;
            check("tk_noflush", {31'd0, flush}, 32'd0);
            next_cycle(); clear_inputs();
        end
        // One not-taken: a saturated counter drops to 10, still predicting taken.
        ex_branch(32'h40, 1'b0, 1'b1, 32'h80);
        #1;
        check("nt_flush", {31'd0, flush}, 32'd1);
        next_cycle(); clear_inputs(); #1;
        check("nt_pc", pc, 32'h44);
        check("nt_mis", {16'd0, mispred_count}, 32'd2);
        check("nt_br", {16'd0, br_count}, 32'd4);
        dec_jump(32'h40);
        next_cycle(); clear_inputs(); #1;
        check("sat_pred", {31'd0, prediction}, 32'd1);

        // jalr with stall and decoder jump in the same cycle: redirect wins.
        ex_valid   = 1'b1;
        ex_is_jalr = 1'b1;
        ex_target  = 32'h300;
        stall      = 1'b1;
        dec_jump(32'h500);
        #1;
        check("jalr_flush", {31'd0, flush}, 32'd1);
        next_cycle(); clear_inputs(); #1;
        check("jalr_pc", pc, 32'h300);
        check("jalr_mis", {16'd0, mispred_count}, 32'd3);

        // Stall plus decoder jump holds; jump takes effect once stall drops.
        stall = 1'b1;
        dec_jump(32'h500);
        next_cycle(); #1;
        check("stall_hold", pc, 32'h300);
        stall = 1'b0;
        next_cycle(); clear_inputs(); #1;
        check("stall_release", pc, 32'h500);

        // A bubble carrying mispredict-looking fields does nothing.
        ex_branch(32'h40, 1'b1, 1'b0, 32'h80);
        ex_valid = 1'b0;
        #1;
        check("bubble_flush", {31'd0, flush}, 32'd0);
        next_cycle(); clear_inputs(); #1;
        check("bubble_pc", pc, 32'h504);

        // PC wrap.
        dec_jump(32'hFFFF_FFFC);
        next_cycle(); clear_inputs(); #1;
        check("wrap_pre", pc, 32'hFFFF_FFFC);
        next_cycle(); #1;
        check("wrap_pc", pc, 32'h0);

        // Asynchronous reset between edges.
        #1;
        reset = 1'b0;
        #1;
        check("arst_pc", pc, RST_PC);
        check("arst_fvalid", {31'd0, fetch_valid}, 32'd0);
        check("arst_br", {16'd0, br_count}, 32'd0);
        check("arst_mis", {16'd0, mispred_count}, 32'd0);
        next_cycle();

        // Release; EX activity in BOOT is ignored.
        reset = 1'b1;
        ex_valid   = 1'b1;
        ex_is_jalr = 1'b1;
        ex_target  = 32'h700;
        #1;
        check("boot_ex_flush", {31'd0, flush}, 32'd0);
        next_cycle(); clear_inputs(); #1;
        check("boot_ex_pc", pc, RST_PC);
        check("boot_ex_mis", {16'd0, mispred_count}, 32'd0);

        // Training at 0x40 is gone: back to weakly not-taken.
        dec_jump(32'h40);
        next_cycle(); clear_inputs(); #1;
        check("post_rst_pc", pc, 32'h40);
        check("post_rst_pred", {31'd0, prediction}, 32'd0);

        repeat (2) next_cycle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_redirect_ctrl.md
# fetch_redirect_ctrl

Owns the fetch PC and sequences the early-jump decoder in the IF stage. It supplies the decoder's `prediction` input from a 2-bit branch history table and selects the next PC from four sources: sequential, decoder early jump, EX-stage mispredict correction, and jalr resolution. It asserts flush on EX redirects and trains the BHT from resolved branches.

## Interface
- `BHT_ENTRIES`, 64: BHT depth; power of two, 4..1024.
- `RESET_PC`, 32'h0000_0000: PC loaded on reset.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `stall`  in  1  hazard hold; freezes PC.
- `dec_jump_flag`  in  1  decoder early jump (jal, or predicted-taken branch).
- `dec_jump_address`  in  32  decoder jump target.
- `ex_valid`  in  1  EX-stage instruction is valid (not a bubble).
- `ex_is_branch`  in  1  EX instruction is a conditional branch.
- `ex_is_jalr`  in  1  EX instruction is jalr.
- `ex_taken`  in  1  resolved branch outcome.
- `ex_pred`  in  1  prediction carried down the pipe with the instruction.
- `ex_pc`  in  32  PC of the EX instruction.
- `ex_target`  in  32  resolved branch or jalr target.
- `pc`  out  32  current fetch PC, to imem and decoder.
- `prediction`  out  1  BHT prediction for `pc`, to decoder and the pipe.
- `fetch_valid`  out  1  `pc` is a real fetch.
- `flush`  out  1  squash IF/ID and ID/EX this cycle.
- `br_count`  out  16  resolved branches, saturating.
- `mispred_count`  out  16  branch mispredicts plus jalr redirects, saturating.

## Operation
- FSM states: BOOT and RUN. Reset enters BOOT. BOOT goes to RUN unconditionally after one cycle. RUN is held until reset.
- In BOOT: `fetch_valid`=0, `pc` is held, and EX inputs are ignored. In RUN: `fetch_valid`=1.
- `ex_mispred` = `ex_valid` & `ex_is_branch` & (`ex_taken` != `ex_pred`).
- `ex_redirect` = `ex_mispred` | (`ex_valid` & `ex_is_jalr`).
- Next-PC priority in RUN, highest first:
  - `ex_redirect`: load `ex_target` for a jalr or a taken branch, otherwise `ex_pc`+4.
  - `stall`: hold `pc`.
  - `dec_jump_flag`: load `dec_jump_address`.
  - Otherwise: load `pc`+4.
- `flush` = RUN & `ex_redirect`. It is combinational and lasts one cycle.
- PC arithmetic is 32-bit modulo; 32'hFFFF_FFFC+4 = 0.
- BHT index = `pc`[log2(BHT_ENTRIES)+1:2]. `prediction` = counter[1] at that index, read combinationally.
- BHT update: when `ex_valid` & `ex_is_branch`, the entry indexed by `ex_pc` increments if taken, else decrements, saturating at 00 and 11.
- Counters: `br_count` increments on `ex_valid` & `ex_is_branch`. `mispred_count` increments on `ex_redirect`. Both saturate at 16'hFFFF.

## Timing
- Reset values: `pc`=RESET_PC, `fetch_valid`=0, `flush`=0, both counters 0, every BHT entry 01 (weakly not-taken), state BOOT.
- Redirect latency: the redirect is seen in cycle N and the new `pc` is valid in N+1. The wrong-path fetch in N is covered by `flush` in N.
- The decoder's jump in cycle N appears as `pc` in N+1, giving a one-bubble taken-jump penalty.
- Simultaneous redirect and stall: the redirect wins and `pc` updates.
- Simultaneous stall and decoder jump: `pc` holds. The decoder re-evaluates the same instruction next cycle.
- BHT read and write to the same index in the same cycle: the read returns the old value; there is no bypass.
- Reset asserted mid-operation: all state returns to reset values immediately, regardless of clock. No BHT training is retained.

## Structure
- The shared package `fetch_pkg` holds:
  - the state enum {BOOT, RUN};
  - the counter encodings SNT=00, WNT=01, WT=10, ST=11;
  - the BHT reset value WNT;
  - the PC increment constant 4.
- Sub-module `branch_history_table`: parameterized depth, one combinational read port, one synchronous update port, async active-low reset to WNT.

## Test plan
- Reset release with RESET_PC=0x100 -> `fetch_valid`=0 for one cycle, then `pc` sequence 0x100, 0x104, 0x108.
- `dec_jump_flag`=1 with address 0x200 at `pc`=0x104 -> next `pc`=0x200 and `flush`=0.
- Branch at 0x40 resolves taken with `ex_pred`=0 and target 0x80 -> `flush`=1 for one cycle, next `pc`=0x80, `mispred_count`+1, entry at 0x40 becomes 10.
- Branch at 0x40 is taken three times, then fetched again -> `prediction`=1 and the counter stays 11.
- jalr in EX with `stall`=1 and `dec_jump_flag`=1 in the same cycle -> `pc` goes to `ex_target` and `flush`=1.
- `pc`=0xFFFF_FFFC with no events -> next `pc`=0. Reset asserted between clock edges -> `pc`=RESET_PC immediately.
